// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter and its lane aligner.
package mem_port_arbiter_pkg;

  localparam int unsigned BUS_W            = 64;
  localparam int unsigned INST_W           = 32;
  localparam int unsigned OFF_W            = 3;
  localparam int unsigned SHAMT_W          = 6;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned TIMEOUT_DEF      = 255;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RSP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // Request as presented to memory: aligned address, lane-shifted data/mask.
  typedef struct packed {
    logic             we;
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] wdata;
    logic [BUS_W-1:0] wmask;
  } mem_req_t;

  function automatic logic [BUS_W-1:0] align_addr(input logic [BUS_W-1:0] a);
    return {a[BUS_W-1:OFF_W], OFF_W'(0)};
  endfunction

  function automatic logic [SHAMT_W-1:0] lane_shamt(input logic [OFF_W-1:0] off);
    return {off, 3'b000};
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a requester's low-aligned view and the 64-bit memory line.
module mem_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [OFF_W-1:0]  wr_off_i,
  input  logic [BUS_W-1:0]  wdata_i,
  input  logic [BUS_W-1:0]  wmask_i,
  output logic [BUS_W-1:0]  wdata_c_o,
  output logic [BUS_W-1:0]  wmask_c_o,
  input  logic [OFF_W-1:0]  rd_off_i,
  input  logic [BUS_W-1:0]  rdata_i,
  output logic [BUS_W-1:0]  rdata_c_o,
  output logic [INST_W-1:0] inst_c_o
);

  assign wdata_c_o = wdata_i << lane_shamt(wr_off_i);
  assign wmask_c_o = wmask_i << lane_shamt(wr_off_i);
  assign rdata_c_o = rdata_i >> lane_shamt(rd_off_i);

  // Fetch addresses are 4-byte aligned, so only bit 2 selects the word.
  assign inst_c_o  = rd_off_i[2] ? rdata_i[BUS_W-1:INST_W] : rdata_i[INST_W-1:0];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between instruction fetch and the data path,
// one transaction outstanding, data-priority with a starvation guard for fetch.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned TIMEOUT      = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req_valid,
  input  logic [BUS_W-1:0]  if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [INST_W-1:0] if_rsp_inst,
  output logic              if_rsp_err,

  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [BUS_W-1:0]  d_req_addr,
  input  logic [BUS_W-1:0]  d_req_wdata,
  input  logic [BUS_W-1:0]  d_req_wmask,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [BUS_W-1:0]  d_rsp_rdata,
  output logic              d_rsp_err,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [BUS_W-1:0]  mem_req_addr,
  output logic [BUS_W-1:0]  mem_req_wdata,
  output logic [BUS_W-1:0]  mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [BUS_W-1:0]  mem_rsp_rdata,

  output logic              busy
);

  localparam int unsigned STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int unsigned WAIT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [OFF_W-1:0]    off_q, off_d;
  mem_req_t            req_q, req_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;

  logic                if_win_c;
  logic                d_win_c;
  logic                starved_c;
  logic                timeout_c;
  logic [BUS_W-1:0]    wdata_sh_c;
  logic [BUS_W-1:0]    wmask_sh_c;
  logic [BUS_W-1:0]    rdata_sh_c;
  logic [INST_W-1:0]   inst_c;

  mem_lane_align u_lane_align (
    .wr_off_i  (d_req_addr[OFF_W-1:0]),
    .wdata_i   (d_req_wdata),
    .wmask_i   (d_req_wmask),
    .wdata_c_o (wdata_sh_c),
    .wmask_c_o (wmask_sh_c),
    .rd_off_i  (off_q),
    .rdata_i   (mem_rsp_rdata),
    .rdata_c_o (rdata_sh_c),
    .inst_c_o  (inst_c)
  );

  // Fetch wins only when data is idle or fetch has been passed over too often.
  assign starved_c = (starve_q == STARVE_W'(STARVE_LIMIT));
  assign if_win_c  = if_req_valid && (!d_req_valid || starved_c);
  assign d_win_c   = d_req_valid && !if_win_c;
  assign timeout_c = (TIMEOUT != 0) && (wait_q == WAIT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_IF;
      off_q    <= '0;
      req_q    <= '0;
      starve_q <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      off_q    <= off_d;
      req_q    <= req_d;
      starve_q <= starve_d;
      wait_q   <= wait_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    off_d        = off_q;
    req_d        = req_q;
    starve_d     = starve_q;
    wait_d       = wait_q;
    if_req_ready = 1'b0;
    d_req_ready  = 1'b0;
    if_rsp_valid = 1'b0;
    if_rsp_inst  = '0;
    if_rsp_err   = 1'b0;
    d_rsp_valid  = 1'b0;
    d_rsp_rdata  = '0;
    d_rsp_err    = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (if_win_c || d_win_c) begin
          if_req_ready = if_win_c;
          d_req_ready  = d_win_c;
          state_d      = ARB_REQ;
          if (if_win_c) begin
            owner_d     = OWN_IF;
            off_d       = if_req_addr[OFF_W-1:0];
            req_d.we    = 1'b0;
            req_d.addr  = align_addr(if_req_addr);
            req_d.wdata = '0;
            req_d.wmask = '0;
            starve_d    = '0;
          end else begin
            owner_d     = OWN_D;
            off_d       = d_req_addr[OFF_W-1:0];
            req_d.we    = d_req_we;
            req_d.addr  = align_addr(d_req_addr);
            req_d.wdata = d_req_we ? wdata_sh_c : '0;
            req_d.wmask = d_req_we ? wmask_sh_c : '0;
            if (!if_req_valid) begin
              starve_d = '0;
            end else if (!starved_c) begin
              starve_d = starve_q + STARVE_W'(1);
            end
          end
        end
      end

      ARB_REQ: begin
        if (mem_req_ready) begin
          state_d = ARB_RSP;
          wait_d  = '0;
        end
      end

      ARB_RSP: begin
        if (mem_rsp_valid || timeout_c) begin
          state_d = ARB_IDLE;
          if (owner_q == OWN_IF) begin
            if_rsp_valid = 1'b1;
            if_rsp_err   = !mem_rsp_valid;
            if_rsp_inst  = mem_rsp_valid ? inst_c : '0;
          end else begin
            d_rsp_valid  = 1'b1;
            d_rsp_err    = !mem_rsp_valid;
            d_rsp_rdata  = (mem_rsp_valid && !req_q.we) ? rdata_sh_c : '0;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      default: state_d = ARB_IDLE;
    endcase

    // Reset abandons the transaction silently: no grant, no response.
    if (rst) begin
      if_req_ready = 1'b0;
      d_req_ready  = 1'b0;
      if_rsp_valid = 1'b0;
      if_rsp_inst  = '0;
      if_rsp_err   = 1'b0;
      d_rsp_valid  = 1'b0;
      d_rsp_rdata  = '0;
      d_rsp_err    = 1'b0;
    end
  end

  assign mem_req_valid = (state_q == ARB_REQ);
  assign mem_req_we    = req_q.we;
  assign mem_req_addr  = req_q.addr;
  assign mem_req_wdata = req_q.wdata;
  assign mem_req_wmask = req_q.wmask;
  assign busy          = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: alignment, lane shifts, priority/starvation,
// stalls, timeout and mid-transaction reset.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_valid;
  logic [63:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_inst;
  logic        if_rsp_err;
  logic        d_req_valid;
  logic        d_req_we;
  logic [63:0] d_req_addr;
  logic [63:0] d_req_wdata;
  logic [63:0] d_req_wmask;
  logic        d_req_ready;
  logic        d_rsp_valid;
  logic [63:0] d_rsp_rdata;
  logic        d_rsp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [63:0] mem_req_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;
  logic        busy;

  int n_tot;
  int n_bad;

  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_valid  (if_req_valid),
    .if_req_addr   (if_req_addr),
    .if_req_ready  (if_req_ready),
    .if_rsp_valid  (if_rsp_valid),
    .if_rsp_inst   (if_rsp_inst),
    .if_rsp_err    (if_rsp_err),
    .d_req_valid   (d_req_valid),
    .d_req_we      (d_req_we),
    .d_req_addr    (d_req_addr),
    .d_req_wdata   (d_req_wdata),
    .d_req_wmask   (d_req_wmask),
    .d_req_ready   (d_req_ready),
    .d_rsp_valid   (d_rsp_valid),
    .d_rsp_rdata   (d_rsp_rdata),
    .d_rsp_err     (d_rsp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wmask (mem_req_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From REQ: accept immediately, respond on the next cycle, return to IDLE.
  task automatic serve(input logic [63:0] rdata);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = rdata;
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit exp_if [10];
    int lat;
    logic [1:0] rdy;

    n_tot = 0;
    n_bad = 0;
    rst = 1'b1;
    if_req_valid = 1'b1;
    if_req_addr  = 64'h8000_0000;
    d_req_valid  = 1'b1;
    d_req_we     = 1'b0;
    d_req_addr   = 64'h8000_0008;
    d_req_wdata  = '0;
    d_req_wmask  = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;

    // Reset: both requests pending, nothing may be granted.
    tick();
    tick();
    chk("rst_if_ready", 64'(if_req_ready), 64'd0);
    chk("rst_d_ready", 64'(d_req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_mem_addr", mem_req_addr, 64'd0);
    rst = 1'b0;
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    tick();

    // Load, unaligned, best-case latency.
    d_req_valid = 1'b1;
    d_req_we    = 1'b0;
    d_req_addr  = 64'h8000_0013;
    #1;
    chk("ld_d_ready", 64'(d_req_ready), 64'd1);
    chk("ld_if_ready", 64'(if_req_ready), 64'd0);
    chk("ld_mem_valid_n", 64'(mem_req_valid), 64'd0);
    tick();
    d_req_valid = 1'b0;
    chk("ld_mem_valid_n1", 64'(mem_req_valid), 64'd1);
    chk("ld_mem_addr", mem_req_addr, 64'h8000_0010);
    chk("ld_mem_we", 64'(mem_req_we), 64'd0);
    chk("ld_busy", 64'(busy), 64'd1);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 64'h1122_3344_5566_7788;
    #1;
    chk("ld_rsp_valid", 64'(d_rsp_valid), 64'd1);
    chk("ld_rsp_rdata", d_rsp_rdata, 64'h0000_0011_2233_4455);
    chk("ld_rsp_err", 64'(d_rsp_err), 64'd0);
    chk("ld_if_rsp", 64'(if_rsp_valid), 64'd0);
    tick();
    mem_rsp_valid = 1'b0;
    chk("ld_idle", 64'(busy), 64'd0);
    chk("ld_rsp_done", 64'(d_rsp_valid), 64'd0);

    // Byte store at lane 5.
    d_req_valid = 1'b1;
    d_req_we    = 1'b1;
    d_req_addr  = 64'h8000_0005;
    d_req_wdata = 64'hAB;
    d_req_wmask = 64'hFF;
    #1;
    chk("sb_ready", 64'(d_req_ready), 64'd1);
    tick();
    d_req_valid = 1'b0;
    chk("sb_mem_addr", mem_req_addr, 64'h8000_0000);
    chk("sb_mem_we", 64'(mem_req_we), 64'd1);
    chk("sb_mem_wdata", mem_req_wdata, 64'h0000_AB00_0000_0000);
    chk("sb_mem_wmask", mem_req_wmask, 64'h0000_FF00_0000_0000);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("sb_ack", 64'(d_rsp_valid), 64'd1);
    chk("sb_ack_rdata", d_rsp_rdata, 64'd0);
    tick();
    mem_rsp_valid = 1'b0;

    // Fetch from the upper word.
    if_req_valid = 1'b1;
    if_req_addr  = 64'h8000_0004;
    #1;
    chk("if_ready", 64'(if_req_ready), 64'd1);
    chk("if_d_ready", 64'(d_req_ready), 64'd0);
    tick();
    if_req_valid = 1'b0;
    chk("if_mem_addr", mem_req_addr, 64'h8000_0000);
    chk("if_mem_we", 64'(mem_req_we), 64'd0);
    chk("if_mem_wmask", mem_req_wmask, 64'd0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 64'hDEAD_BEEF_0000_0013;
    #1;
    chk("if_rsp_valid", 64'(if_rsp_valid), 64'd1);
    chk("if_rsp_inst", 64'(if_rsp_inst), 64'hDEAD_BEEF);
    chk("if_rsp_err", 64'(if_rsp_err), 64'd0);
    chk("if_no_d_rsp", 64'(d_rsp_valid), 64'd0);
    tick();
    mem_rsp_valid = 1'b0;

    // Both valid continuously: four data grants, then fetch is forced through.
    exp_if = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    if_req_valid = 1'b1;
    if_req_addr  = 64'h8000_0000;
    d_req_valid  = 1'b1;
    d_req_we     = 1'b0;
    d_req_addr   = 64'h8000_0100;
    for (int i = 0; i < 10; i++) begin
      #1;
      rdy = {if_req_ready, d_req_ready};
      chk($sformatf("starve_grant%0d", i), 64'(rdy), exp_if[i] ? 64'd2 : 64'd1);
      tick();
      serve(64'd0);
    end
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    tick();

    // Memory stalls 10 cycles; a stale response in REQ must be dropped.
    d_req_valid = 1'b1;
    d_req_we    = 1'b1;
    d_req_addr  = 64'h8000_0020;
    d_req_wdata = 64'h1234;
    d_req_wmask = 64'hFFFF;
    tick();
    mem_rsp_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall_valid%0d", i), 64'(mem_req_valid), 64'd1);
      chk($sformatf("stall_addr%0d", i), mem_req_addr, 64'h8000_0020);
      chk($sformatf("stall_wdata%0d", i), mem_req_wdata, 64'h1234);
      chk($sformatf("stall_nogrant%0d", i), 64'(d_req_ready), 64'd0);
      chk($sformatf("stall_norsp%0d", i), 64'(d_rsp_valid), 64'd0);
      tick();
    end
    mem_rsp_valid = 1'b0;
    d_req_valid   = 1'b0;
    serve(64'd0);
    chk("stall_idle", 64'(busy), 64'd0);

    // Timeout: no response ever; error pulse 8 cycles after the accept cycle.
    d_req_valid = 1'b1;
    d_req_we    = 1'b0;
    d_req_addr  = 64'h8000_0008;
    tick();
    d_req_valid   = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    lat = 1;
    while (!d_rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("to_latency", 64'(lat), 64'd8);
    chk("to_err", 64'(d_rsp_err), 64'd1);
    chk("to_rdata", d_rsp_rdata, 64'd0);
    tick();
    chk("to_idle", 64'(busy), 64'd0);
    chk("to_pulse_end", 64'(d_rsp_valid), 64'd0);

    // Reset while in RSP, then a stale response arrives.
    d_req_valid = 1'b1;
    d_req_addr  = 64'h8000_0030;
    tick();
    d_req_valid   = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("rr_in_rsp", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_busy", 64'(busy), 64'd0);
    chk("rr_mem_valid", 64'(mem_req_valid), 64'd0);
    chk("rr_mem_addr", mem_req_addr, 64'd0);
    chk("rr_d_rsp", 64'(d_rsp_valid), 64'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 64'h5555_AAAA_5555_AAAA;
    #1;
    chk("rr_stale_d", 64'(d_rsp_valid), 64'd0);
    chk("rr_stale_if", 64'(if_rsp_valid), 64'd0);
    tick();
    mem_rsp_valid = 1'b0;
    chk("rr_still_idle", 64'(busy), 64'd0);
    chk("rr_no_req", 64'(mem_req_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencing controller that shares the core's single 64-bit memory port between instruction fetch (IF) and the data load/store path fed by decode (mem_ren/mem_wen/address/wdata/wmask). One transaction is outstanding at a time. Data requests have priority, and a starvation counter guarantees IF progress. The arbiter aligns addresses to 8 bytes, lane-shifts write data and write masks, and routes the response back to the owner. A timeout returns an error if memory never responds.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive data grants while IF is pending before IF is forced to win.
- TIMEOUT, 255: cycles in RSP before an error response; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- if_req_valid  in  1  fetch request.
- if_req_addr  in  64  fetch byte address, 4-byte aligned.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_rsp_valid  out  1  one-cycle fetch response pulse.
- if_rsp_inst  out  32  instruction word.
- if_rsp_err  out  1  timeout on fetch.
- d_req_valid  in  1  data request.
- d_req_we  in  1  1 = store, 0 = load.
- d_req_addr  in  64  byte address.
- d_req_wdata  in  64  store data, low-aligned.
- d_req_wmask  in  64  bit mask, low-aligned (e.g. 'hFF for SB).
- d_req_ready  out  1  data request accepted.
- d_rsp_valid  out  1  one-cycle data response pulse; also pulses as the store ack.
- d_rsp_rdata  out  64  load data shifted right by addr[2:0]*8; 0 for stores.
- d_rsp_err  out  1  timeout on data.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_we  out  1  write.
- mem_req_addr  out  64  addr & ~7.
- mem_req_wdata  out  64  wdata << (addr[2:0]*8).
- mem_req_wmask  out  64  wmask << (addr[2:0]*8), truncated to 64 bits.
- mem_rsp_valid  in  1  memory response.
- mem_rsp_rdata  in  64  memory line.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, REQ, RSP.
- IDLE:
  - Grant decision is combinational from the two valids. The winner's ready is 1; the loser's ready is 0.
  - Winner: data if d_req_valid, unless starve_cnt == STARVE_LIMIT and if_req_valid, in which case IF wins.
  - On grant, latch owner, we, offset addr[2:0] and the aligned/shifted request fields, then go to REQ.
- REQ: mem_req_valid = 1 with the latched fields held stable. On mem_req_ready go to RSP and clear wait_cnt.
- RSP:
  - On mem_rsp_valid, pulse the owner's rsp_valid in the same cycle and go to IDLE.
  - IF data: if_rsp_inst = off[2] ? rdata[63:32] : rdata[31:0].
  - Load data: d_rsp_rdata = rdata >> (off*8). Stores return 0.
  - Otherwise wait_cnt increments. When TIMEOUT != 0 and wait_cnt == TIMEOUT-1 with no response, pulse the owner's rsp_valid with err = 1 and data 0, then go to IDLE.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on each data grant while if_req_valid = 1.
  - Clears on any IF grant, and on a data grant while if_req_valid = 0.
- mem_rsp_valid is ignored in IDLE and REQ (stale responses are dropped).
- Requesters hold valid and fields stable until ready. Responses have no backpressure. Loads and stores do no sign extension; that is done downstream.

## Timing
- Reset: state = IDLE, owner = IF, starve_cnt = 0, wait_cnt = 0. All outputs are 0, including both readys.
- Reset mid-transaction abandons it. No response pulse is issued. The memory is not notified.
- Grant at cycle N (IDLE, ready = 1). mem_req_valid is high from N+1.
- Best case: mem_req_ready at N+1, mem_rsp_valid at N+2, rsp pulse at N+2, IDLE at N+3.
- Next grant no earlier than N+3, giving a throughput of 1 transaction per 3 cycles minimum.
- A simultaneous IF and data request in IDLE grants exactly one; the other waits with ready = 0.
- A timeout response occurs TIMEOUT cycles after entering RSP.

## Structure
- Put FSM state encodings (ARB_IDLE, ARB_REQ, ARB_RSP), owner encodings (OWN_IF, OWN_D) and STARVE/TIMEOUT default constants in defines.v beside `BUS_64`.
- One sub-module, mem_lane_align, holds the combinational write shift (data and mask) and read shift by offset. It is reused by a future cache.

## Test plan
- Load at d_req_addr 0x80000013, mem_rsp_rdata 0x1122334455667788 -> mem_req_addr 0x80000010; d_rsp_rdata 0x0000001122334455, 3-cycle latency.
- SB at addr 0x80000005, wdata 0xAB, wmask 0xFF -> mem_req_wdata 0x0000AB0000000000, wmask 0x0000FF0000000000; d_rsp_valid ack with rdata 0.
- IF at 0x80000004, rdata 0xDEADBEEF_00000013 -> if_rsp_inst 0xDEADBEEF.
- IF and data both valid continuously, STARVE_LIMIT 4 -> grant order D,D,D,D,IF,D,D,D,D,IF.
- mem_req_ready held 0 for 10 cycles -> mem_req_valid stays 1 with stable fields; no response; no new grant.
- TIMEOUT 8, no mem_rsp_valid -> d_rsp_valid with d_rsp_err = 1 8 cycles after RSP entry. A rst during RSP gives IDLE with all outputs 0 next cycle, and a later stale mem_rsp_valid is ignored.
